// File: rtl/t5_seqr_pkg.sv
// T5 pipeline sequencer shared definitions.
// State encoding, PC-select codes and opcode constants.
package t5_seqr_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BRA  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_RST  = 2'b11;

  localparam logic [4:0] OPC_LOAD = 5'b00000;

endpackage

// File: rtl/t5_seqr_if.sv
// T5 sequencer bus bundle: Wishbone handshakes,
// decode/execute status in, stage controls out.
interface t5_seqr_if;

  logic       iwb_ack;
  logic       iwb_stb;
  logic       dwb_stb;
  logic       dwb_ack;
  logic [4:0] dopc;
  logic [4:0] drd;
  logic [4:0] rs1a;
  logic [4:0] rs2a;
  logic       dexc;
  logic       xbra;
  logic       sena;
  logic       sexe;
  logic       sflush;
  logic       sbub;
  logic [1:0] spcsel;

  modport master (
    input  iwb_ack, dwb_stb, dwb_ack,
    input  dopc, drd, rs1a, rs2a,
    input  dexc, xbra,
    output iwb_stb, sena, sexe,
    output sflush, sbub, spcsel
  );

  modport slave (
    output iwb_ack, dwb_stb, dwb_ack,
    output dopc, drd, rs1a, rs2a,
    output dexc, xbra,
    input  iwb_stb, sena, sexe,
    input  sflush, sbub, spcsel
  );

endinterface

// File: rtl/t5_hzd.sv
// T5 load-use hazard comparator.
// Flags a load in decode whose rd feeds the next instruction.
module t5_hzd
  import t5_seqr_pkg::*;
(
  input  logic [4:0] dopc,
  input  logic [4:0] drd,
  input  logic [4:0] rs1a,
  input  logic [4:0] rs2a,
  output logic       ldhz
);

  assign ldhz = (dopc == OPC_LOAD) && (drd != 5'd0) &&
                ((drd == rs1a) || (drd == rs2a));

endmodule

// File: rtl/t5_seqr.sv
// T5 pipeline sequencer: stage enables, flush,
// bubble and PC select from stall/redirect sources.
module t5_seqr
  import t5_seqr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TRAP_CYC = 2
) (
  input  logic       sclk,
  input  logic       srst,
  t5_seqr_if.master  bus
);

  if (XLEN != 32) begin : g_xlen
    $error("t5_seqr: only XLEN=32 supported");
  end

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       bub_q;
  logic       ldhz;

  t5_hzd u_hzd (
    .dopc (bus.dopc),
    .drd  (bus.drd),
    .rs1a (bus.rs1a),
    .rs2a (bus.rs2a),
    .ldhz (ldhz)
  );

  logic dstall, sel_dst, sel_exc;
  logic sel_bra, sel_hz, sel_nrm;

  // one-hot priority: dstall > dexc > xbra > ldhz
  assign dstall  = bus.dwb_stb & ~bus.dwb_ack;
  assign sel_dst = dstall;
  assign sel_exc = ~dstall & bus.dexc;
  assign sel_bra = ~dstall & ~bus.dexc & bus.xbra;
  assign sel_hz  = ~dstall & ~bus.dexc & ~bus.xbra &
                   ldhz & ~bub_q;
  assign sel_nrm = ~sel_dst & ~sel_exc &
                   ~sel_bra & ~sel_hz;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bus.iwb_stb = 1'b0;
    bus.sena    = 1'b0;
    bus.sexe    = 1'b0;
    bus.sflush  = 1'b0;
    bus.sbub    = 1'b0;
    bus.spcsel  = PC_SEQ;
    if (srst) begin
      bus.spcsel = PC_RST;
    end else begin
      unique case (state)
        S_BOOT: begin
          bus.spcsel = PC_RST;
          bus.sflush = 1'b1;
          state_n    = S_RUN;
        end
        S_RUN: begin
          bus.iwb_stb = 1'b1;
          unique case (1'b1)
            sel_dst: ;
            sel_exc: begin
              bus.sflush = 1'b1;
              bus.spcsel = PC_TRAP;
              cnt_n      = 8'(TRAP_CYC - 1);
              state_n    = S_TRAP;
            end
            sel_bra: begin
              bus.sflush = 1'b1;
              bus.spcsel = PC_BRA;
              bus.sena   = 1'b1;
              bus.sexe   = 1'b1;
              state_n    = bus.iwb_ack ? S_RUN : S_FLUSH;
            end
            sel_hz: begin
              bus.sexe = 1'b1;
              bus.sbub = 1'b1;
            end
            sel_nrm: begin
              bus.sena = bus.iwb_ack;
              bus.sexe = bus.iwb_ack;
            end
          endcase
        end
        S_FLUSH: begin
          // stale fetch completes; kill it
          bus.iwb_stb = 1'b1;
          if (bus.iwb_ack) begin
            bus.sflush = 1'b1;
            state_n    = S_RUN;
          end
        end
        S_TRAP: begin
          if (cnt == 8'd0) begin
            bus.spcsel = PC_TRAP;
            bus.sena   = 1'b1;
            state_n    = S_RUN;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state <= S_BOOT;
      cnt   <= 8'd0;
      bub_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bub_q <= bus.sbub;
    end
  end

endmodule

// File: tb/tb_t5_seqr.sv
// Self-checking bench for t5_seqr: directed scenarios
// then random traffic against a behavioural model.
module tb_t5_seqr;

  localparam int TRAP_CYC = 2;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_TRAP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  t5_seqr_if bus ();

  t5_seqr #(.XLEN(32), .TRAP_CYC(TRAP_CYC)) dut (
    .sclk (clk),
    .srst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int mode      = M_BOOT;
  int trap_left = 0;
  bit last_bub  = 1'b0;

  task automatic chk(input string tag,
                     input logic [1:0] got,
                     input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit ack,
                      input bit dstb, input bit dack,
                      input bit exc, input bit bra,
                      input logic [4:0] opc,
                      input logic [4:0] rd,
                      input logic [4:0] r1,
                      input logic [4:0] r2);
    bit e_ena, e_exe, e_stb, e_fl, e_bub;
    logic [1:0] e_pc;
    bit stall, hz;
    int nmode;
    @(negedge clk);
    rst         = r;
    bus.iwb_ack = ack;
    bus.dwb_stb = dstb;
    bus.dwb_ack = dack;
    bus.dexc    = exc;
    bus.xbra    = bra;
    bus.dopc    = opc;
    bus.drd     = rd;
    bus.rs1a    = r1;
    bus.rs2a    = r2;
    #1;
    e_ena = 0; e_exe = 0; e_stb = 0;
    e_fl  = 0; e_bub = 0; e_pc = 2'b00;
    nmode = mode;
    if (r) begin
      e_pc      = 2'b11;
      nmode     = M_BOOT;
      trap_left = 0;
    end else if (mode == M_BOOT) begin
      e_pc  = 2'b11;
      e_fl  = 1;
      nmode = M_RUN;
    end else if (mode == M_RUN) begin
      e_stb = 1;
      stall = dstb && !dack;
      hz = (opc == 5'd0) && (rd != 0) &&
           (rd == r1 || rd == r2) && !last_bub;
      if (stall) begin
      end else if (exc) begin
        e_fl      = 1;
        e_pc      = 2'b10;
        nmode     = M_TRAP;
        trap_left = TRAP_CYC;
      end else if (bra) begin
        e_fl  = 1;
        e_pc  = 2'b01;
        e_ena = 1;
        e_exe = 1;
        nmode = ack ? M_RUN : M_FLUSH;
      end else if (hz) begin
        e_exe = 1;
        e_bub = 1;
      end else begin
        e_ena = ack;
        e_exe = ack;
      end
    end else if (mode == M_FLUSH) begin
      e_stb = 1;
      if (ack) begin
        e_fl  = 1;
        nmode = M_RUN;
      end
    end else begin
      // TRAP lasts TRAP_CYC cycles, last one refetches
      if (trap_left == 1) begin
        e_pc  = 2'b10;
        e_ena = 1;
        nmode = M_RUN;
      end
      trap_left--;
    end
    chk("sena",    {1'b0, bus.sena},    {1'b0, e_ena});
    chk("sexe",    {1'b0, bus.sexe},    {1'b0, e_exe});
    chk("iwb_stb", {1'b0, bus.iwb_stb}, {1'b0, e_stb});
    chk("sflush",  {1'b0, bus.sflush},  {1'b0, e_fl});
    chk("sbub",    {1'b0, bus.sbub},    {1'b0, e_bub});
    chk("spcsel",  bus.spcsel,          e_pc);
    last_bub = r ? 1'b0 : e_bub;
    mode     = nmode;
  endtask

  localparam logic [4:0] OP = 5'b01100;
  localparam logic [4:0] LD = 5'b00000;

  initial begin
    bus.iwb_ack = 0; bus.dwb_stb = 0; bus.dwb_ack = 0;
    bus.dexc = 0; bus.xbra = 0; bus.dopc = OP;
    bus.drd = 0; bus.rs1a = 0; bus.rs2a = 0;
    // reset 2 cycles, boot with stale ack, run
    step(1, 0, 0, 0, 0, 0, OP, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // instruction bus wait 3 cycles
    repeat (3) step(0, 0, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // load-use bubble, then hazard gone, then rd=0
    step(0, 1, 0, 0, 0, 0, LD, 5, 5, 2);
    step(0, 1, 0, 0, 0, 0, LD, 5, 5, 2);
    step(0, 1, 0, 0, 0, 0, OP, 3, 4, 6);
    step(0, 1, 0, 0, 0, 0, LD, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, LD, 7, 1, 7);
    step(0, 1, 0, 0, 0, 0, OP, 7, 1, 7);
    // branch with pending fetch
    step(0, 0, 0, 0, 0, 1, OP, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // branch with fetch acked: no flush state
    step(0, 1, 0, 0, 0, 1, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // data stall holds branch, then redirect
    step(0, 1, 1, 0, 0, 1, OP, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, OP, 0, 0, 0);
    step(0, 1, 1, 1, 0, 1, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // exception beats branch; trap and exit
    step(0, 1, 0, 0, 1, 1, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // reset inside trap
    step(0, 1, 0, 0, 1, 0, OP, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, OP, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, a, ds, da, ex, br;
      logic [4:0] opc, rd, r1, r2;
      r   = ($urandom_range(0, 63) == 0);
      a   = $urandom_range(0, 1);
      ds  = ($urandom_range(0, 3) == 0);
      da  = $urandom_range(0, 1);
      ex  = ($urandom_range(0, 15) == 0);
      br  = ($urandom_range(0, 7) == 0);
      opc = $urandom_range(0, 1) ? LD : 5'($urandom);
      rd  = 5'($urandom_range(0, 3));
      r1  = 5'($urandom_range(0, 3));
      r2  = 5'($urandom_range(0, 3));
      step(r, a, ds, da, ex, br, opc, rd, r1, r2);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
